led_pattern_sequencer: RTL and testbench

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

---
 rtl/led_seq_pkg.sv | 20 ++
 rtl/led_pattern_sequencer_dwell_counter.sv | 29 ++
 rtl/led_pattern_sequencer.sv | 165 ++++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DWELL = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        MODE_LOOP     = 2'd0,
        MODE_ONESHOT  = 2'd1,
        MODE_PINGPONG = 2'd2,
        MODE_RSVD     = 2'd3
    } seq_mode_e;

    localparam logic [31:0] LED_ADDR_DEFAULT = 32'hFFFF_FFFC;

endpackage

// File: rtl/led_pattern_sequencer_dwell_counter.sv
// Dwell down-counter: loads a length, counts down while enabled and not paused,
// and flags terminal count.
module dwell_counter #(
    parameter int DWELL_W = 22
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               enable,
    input  logic               pause,
    output logic               zero
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (enable && !pause && (count != '0)) begin
            count <= count - DWELL_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/led_pattern_sequencer.sv
// Steps through a small pattern table, writing each word to an MMIO LED
// register and dwelling between writes; supports loop, one-shot and ping-pong.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int          NUM_STEPS = 6,
    parameter int          DATA_W    = 32,
    parameter int          DWELL_W   = 22,
    parameter logic [31:0] LED_ADDR  = LED_ADDR_DEFAULT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         pause,
    input  logic [1:0]                   mode,
    input  logic [DWELL_W-1:0]           dwell_cycles,
    input  logic                         cfg_we,
    input  logic [$clog2(NUM_STEPS)-1:0] cfg_idx,
    input  logic [DATA_W-1:0]            cfg_data,
    input  logic                         wr_ready,
    output logic                         mem_wren,
    output logic [31:0]                  mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    output logic [$clog2(NUM_STEPS)-1:0] step_idx,
    output logic                         busy,
    output logic                         done
);

    localparam int                IDX_W     = $clog2(NUM_STEPS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_STEPS - 1);
    localparam logic [IDX_W:0]    STEPS_EXT = (IDX_W + 1)'(NUM_STEPS);

    seq_state_e         state, state_n;
    seq_mode_e          mode_lat, mode_n;
    logic               dir_down, dir_n;
    logic [IDX_W-1:0]   step_n;
    logic [DWELL_W-1:0] dwell_lat, dwell_n;
    logic               wren_n;
    logic [DATA_W-1:0]  wdata_n;
    logic               cnt_load, cnt_zero;
    logic [DATA_W-1:0]  table_q [NUM_STEPS];

    dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (dwell_lat),
        .enable   (state == ST_DWELL),
        .pause    (pause),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_STEPS; i++) table_q[i] <= '0;
        end else if (cfg_we && ({1'b0, cfg_idx} < STEPS_EXT)) begin
            table_q[cfg_idx] <= cfg_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            mode_lat  <= MODE_LOOP;
            dwell_lat <= '0;
            dir_down  <= 1'b0;
            step_idx  <= '0;
            mem_wren  <= 1'b0;
            mem_wdata <= '0;
        end else begin
            state     <= state_n;
            mode_lat  <= mode_n;
            dwell_lat <= dwell_n;
            dir_down  <= dir_n;
            step_idx  <= step_n;
            mem_wren  <= wren_n;
            mem_wdata <= wdata_n;
        end
    end

    always_comb begin
        state_n  = state;
        mode_n   = mode_lat;
        dwell_n  = dwell_lat;
        dir_n    = dir_down;
        step_n   = step_idx;
        wren_n   = mem_wren;
        wdata_n  = mem_wdata;
        cnt_load = 1'b0;

        if (stop) begin
            state_n = ST_IDLE;
            wren_n  = 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_n  = seq_mode_e'(mode);
                        dwell_n = dwell_cycles;
                        step_n  = '0;
                        dir_n   = 1'b0;
                        state_n = ST_WRITE;
                        wren_n  = 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (wr_ready) begin
                        state_n  = ST_DWELL;
                        wren_n   = 1'b0;
                        cnt_load = 1'b1;
                    end
                end
                ST_DWELL: begin
                    if (!pause && cnt_zero) begin
                        state_n = ST_WRITE;
                        wren_n  = 1'b1;
                        case (mode_lat)
                            MODE_ONESHOT: begin
                                if (step_idx == LAST_IDX) begin
                                    state_n = ST_DONE;
                                    wren_n  = 1'b0;
                                end else begin
                                    step_n = step_idx + IDX_W'(1);
                                end
                            end
                            // Turn around at either end without repeating the end step.
                            MODE_PINGPONG: begin
                                if (!dir_down) begin
                                    if (step_idx == LAST_IDX) begin
                                        dir_n  = 1'b1;
                                        step_n = step_idx - IDX_W'(1);
                                    end else begin
                                        step_n = step_idx + IDX_W'(1);
                                    end
                                end else begin
                                    if (step_idx == '0) begin
                                        dir_n  = 1'b0;
                                        step_n = step_idx + IDX_W'(1);
                                    end else begin
                                        step_n = step_idx - IDX_W'(1);
                                    end
                                end
                            end
                            default: begin
                                step_n = (step_idx == LAST_IDX) ? '0 : step_idx + IDX_W'(1);
                            end
                        endcase
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end

        // The word is captured on WRITE entry so later table writes cannot disturb it.
        if ((state_n == ST_WRITE) && (state != ST_WRITE)) begin
            wdata_n = table_q[step_n];
        end
    end

    assign mem_addr = LED_ADDR;
    assign busy     = (state == ST_WRITE) || (state == ST_DWELL);
    assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench: behavioural model compared every cycle, plus directed
// scenarios with hand-computed expectations and a randomized soak.
module tb_led_pattern_sequencer;

    localparam int N = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [21:0] dwell_cycles = '0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [31:0] cfg_data = '0;
    logic        wr_ready = 1'b1;
    logic        mem_wren;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  step_idx;
    logic        busy, done;

    led_pattern_sequencer #(.NUM_STEPS(6), .DATA_W(32), .DWELL_W(22), .LED_ADDR(32'hFFFF_FFFC)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause), .mode(mode),
        .dwell_cycles(dwell_cycles), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .wr_ready(wr_ready), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .step_idx(step_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures < 40) $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    logic [31:0] TBL [N] = '{32'hFFFF0000, 32'hFFFFFF00, 32'hFF00FF00,
                             32'h0000FFFF, 32'h000000FF, 32'h00FF00FF};

    // Behavioural model: a run is a sequence of positions; the step is derived
    // from the position arithmetically.
    logic [31:0] m_tbl [N] = '{default: 32'h0};
    logic        m_busy = 1'b0, m_done = 1'b0, m_wren = 1'b0;
    logic [31:0] m_wdata = '0;
    int          m_step = 0, m_pos = 0, m_left = 0, m_mode = 0, m_dwell = 0;

    function automatic int step_of(input int md, input int pos);
        int p;
        if (md == 2) begin
            p = pos % (2 * N - 2);
            return (p < N) ? p : (2 * N - 2 - p);
        end
        return pos % N;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_done = 0; m_wren = 0; m_wdata = '0;
            m_step = 0; m_pos = 0; m_left = 0;
            for (int i = 0; i < N; i++) m_tbl[i] = '0;
        end else begin
            if (stop) begin
                m_busy = 0; m_done = 0; m_wren = 0;
            end else if (!m_busy) begin
                if (start) begin
                    m_mode = int'(mode); m_dwell = int'(dwell_cycles);
                    m_pos = 0; m_step = 0; m_busy = 1; m_done = 0;
                    m_wren = 1; m_wdata = m_tbl[0];
                end
            end else if (m_wren) begin
                if (wr_ready) begin
                    m_wren = 0; m_left = m_dwell;
                end
            end else if (!pause) begin
                if (m_left == 0) begin
                    m_pos++;
                    if (m_mode == 1 && m_pos == N) begin
                        m_busy = 0; m_done = 1;
                    end else begin
                        m_step = step_of(m_mode, m_pos);
                        m_wren = 1; m_wdata = m_tbl[m_step];
                    end
                end else begin
                    m_left--;
                end
            end
            if (cfg_we && int'(cfg_idx) < N) m_tbl[cfg_idx] = cfg_data;
        end
    end

    always @(negedge clk) begin
        chk("cyc_wren", mem_wren, m_wren);
        chk("cyc_wdata", mem_wdata, m_wdata);
        chk("cyc_addr", mem_addr, 32'hFFFF_FFFC);
        chk("cyc_step", step_idx, m_step);
        chk("cyc_busy", busy, m_busy);
        chk("cyc_done", done, m_done);
    end

    // Log of accepted writes taken from the bus, for the directed literal checks.
    int          cyc = 0;
    int          log_cyc[$];
    logic [31:0] log_data[$];
    always @(posedge clk) begin
        if (!reset && mem_wren && wr_ready) begin
            log_data.push_back(mem_wdata);
            log_cyc.push_back(cyc);
        end
        cyc++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic run_start(input int md, input int dw);
        mode = 2'(md);
        dwell_cycles = 22'(dw);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    task automatic wait_writes(input int n, input int budget, input string name);
        int k = 0;
        while (log_data.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(name, log_data.size(), n);
    endtask

    initial begin
        int pp_seq [12] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};
        int k;

        repeat (3) tick();
        chk("rst_wren", mem_wren, 0);
        chk("rst_addr", mem_addr, 32'hFFFF_FFFC);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_step", step_idx, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < N; i++) begin
            cfg_we = 1'b1; cfg_idx = 3'(i); cfg_data = TBL[i];
            tick();
        end
        cfg_idx = 3'd6; cfg_data = 32'hDEADBEEF; tick();
        cfg_idx = 3'd7; tick();
        cfg_we = 1'b0;

        // Loop mode.
        clear_log();
        run_start(0, 3);
        wait_writes(7, 60, "loop_cnt");
        for (int i = 0; i < 7 && i < log_data.size(); i++) chk("loop_data", log_data[i], TBL[i % N]);
        for (int i = 1; i < 7 && i < log_data.size(); i++) chk("loop_gap", log_cyc[i] - log_cyc[i-1], 5);
        do_stop();

        // One-shot.
        clear_log();
        run_start(1, 2);
        k = 0;
        while (!done && k < 100) begin tick(); k++; end
        chk("os_done", done, 1);
        chk("os_step", step_idx, 5);
        repeat (10) tick();
        chk("os_writes", log_data.size(), 6);
        chk("os_busy", busy, 0);

        // Ping-pong, started straight from the finished one-shot.
        clear_log();
        run_start(2, 1);
        chk("pp_done_clr", done, 0);
        wait_writes(12, 200, "pp_cnt");
        for (int i = 0; i < 12 && i < log_data.size(); i++) chk("pp_order", log_data[i], TBL[pp_seq[i]]);
        do_stop();

        // Back-pressure then pause.
        clear_log();
        wr_ready = 1'b0;
        run_start(0, 2);
        for (int i = 0; i < 4; i++) begin
            chk("bp_wren", mem_wren, 1);
            chk("bp_wdata", mem_wdata, TBL[0]);
            tick();
        end
        chk("bp_none", log_data.size(), 0);
        wr_ready = 1'b1;
        tick();
        chk("bp_one", log_data.size(), 1);
        pause = 1'b1;
        repeat (10) tick();
        pause = 1'b0;
        wait_writes(2, 50, "pause_cnt");
        if (log_cyc.size() >= 2) chk("pause_gap", log_cyc[1] - log_cyc[0], 14);
        do_stop();

        // Stop and start together during DWELL.
        clear_log();
        run_start(0, 5);
        wait_writes(1, 20, "ss_first");
        tick();
        chk("ss_busy_pre", busy, 1);
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        chk("ss_busy", busy, 0);
        repeat (10) tick();
        chk("ss_idle_busy", busy, 0);
        chk("ss_writes", log_data.size(), 1);

        // Table update to the step currently being written.
        clear_log();
        run_start(0, 3);
        k = 0;
        while (!(mem_wren && step_idx == 3'd2) && k < 50) begin tick(); k++; end
        chk("tu_at_step2", step_idx, 2);
        cfg_we = 1'b1; cfg_idx = 3'd2; cfg_data = 32'h12345678;
        tick();
        cfg_we = 1'b0;
        wait_writes(9, 100, "tu_cnt");
        if (log_data.size() >= 9) begin
            chk("tu_old", log_data[2], TBL[2]);
            chk("tu_new", log_data[8], 32'h12345678);
        end
        do_stop();

        // Reset mid-WRITE.
        clear_log();
        wr_ready = 1'b0;
        run_start(0, 0);
        chk("rw_wren_pre", mem_wren, 1);
        reset = 1'b1;
        #1;
        chk("rw_wren_async", mem_wren, 0);
        chk("rw_busy", busy, 0);
        chk("rw_done", done, 0);
        chk("rw_step", step_idx, 0);
        chk("rw_wdata", mem_wdata, 0);
        tick();
        tick();
        chk("rw_no_write", log_data.size(), 0);
        reset = 1'b0;
        wr_ready = 1'b1;
        tick();
        run_start(0, 0);
        wait_writes(6, 40, "rw_cnt");
        for (int i = 0; i < 6 && i < log_data.size(); i++) chk("rw_tbl_zero", log_data[i], 0);
        do_stop();

        // Randomized soak against the model.
        for (int i = 0; i < 3000; i++) begin
            start        = ($urandom % 20) == 0;
            stop         = ($urandom % 60) == 0;
            pause        = ($urandom % 5) == 0;
            wr_ready     = ($urandom % 3) != 0;
            mode         = 2'($urandom % 4);
            dwell_cycles = 22'($urandom % 5);
            cfg_we       = ($urandom % 8) == 0;
            cfg_idx      = 3'($urandom % 8);
            cfg_data     = $urandom;
            if (($urandom % 500) == 0) reset = 1'b1;
            tick();
            reset = 1'b0;
        end
        start = 0; stop = 0; pause = 0; cfg_we = 0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
